// File: rtl/mem_wb_stage_if.sv
// Bundle of every signal the mem_wb_stage exchanges with its neighbours:
// the execute-stage handshake, the request/acknowledge memory port, the
// register-file write port and the fault/trap reports to control.
// The master modport is the stage itself; the slave modport is its environment.
interface mem_wb_stage_if;
  // Execute-stage handshake and instruction payload
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_op;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic [31:0] ex_link;

  // Memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Register-file write port
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Reports to the control unit
  logic        fault;
  logic        trap;
  logic        trap_cause;

  modport master (
    input  ex_valid, ex_op, ex_result, ex_store_data, ex_rd, ex_link,
    input  mem_ack, mem_rdata,
    output ex_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output wb_en, wb_rd, wb_data,
    output fault, trap, trap_cause
  );

  modport slave (
    output ex_valid, ex_op, ex_result, ex_store_data, ex_rd, ex_link,
    output mem_ack, mem_rdata,
    input  ex_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_en, wb_rd, wb_data,
    input  fault, trap, trap_cause
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and writeback stage that sits right after the ALU.
// ALU, link and trap ops complete in one cycle at full throughput; aligned
// LW/SW park in MEM and hold the memory request until mem_ack arrives.
// Optional feature macro: MEMWB_TIMEOUT_EN -- when defined, a request that sees
// no ack for TIMEOUT_CYCLES cycles is abandoned and reported as a fault.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            rst,
  mem_wb_stage_if.master bus
);

  localparam logic [4:0] OP_LAST_ALU = 5'd20;
  localparam logic [4:0] OP_LW       = 5'd21;
  localparam logic [4:0] OP_SW       = 5'd22;
  localparam logic [4:0] OP_JAL      = 5'd25;
  localparam logic [4:0] OP_JALR     = 5'd26;
  localparam logic [4:0] OP_LI       = 5'd27;
  localparam logic [4:0] OP_LUI      = 5'd28;
  localparam logic [4:0] OP_AUITPC   = 5'd29;
  localparam logic [4:0] OP_ECALL    = 5'd30;
  localparam logic [4:0] OP_EBREAK   = 5'd31;

  // A zero-length timeout would expire before the memory could ever answer.
  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("mem_wb_stage: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {
    S_IDLE,
    S_MEM
  } state_t;

  state_t      r_state;
  logic        r_memReq;
  logic        r_memWe;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic [4:0]  r_memRd;
  logic        r_wbEn;
  logic [4:0]  r_wbRd;
  logic [31:0] r_wbData;
  logic        r_fault;
  logic        r_trap;
  logic        r_trapCause;

`ifdef MEMWB_TIMEOUT_EN
  localparam int COUNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_W-1:0] LAST_WAIT = COUNT_W'(TIMEOUT_CYCLES - 1);
  logic [COUNT_W-1:0] r_waitCount;
`endif

  logic w_writesResult;
  logic w_writesLink;
  logic w_isMem;
  logic w_isTrap;
  logic w_misaligned;

  // Classify the incoming opcode; BT/BF fall through every class and do nothing.
  always_comb begin
    w_writesResult = (bus.ex_op <= OP_LAST_ALU) || (bus.ex_op == OP_LI) ||
                     (bus.ex_op == OP_LUI) || (bus.ex_op == OP_AUITPC);
    w_writesLink   = (bus.ex_op == OP_JAL) || (bus.ex_op == OP_JALR);
    w_isMem        = (bus.ex_op == OP_LW) || (bus.ex_op == OP_SW);
    w_isTrap       = (bus.ex_op == OP_ECALL) || (bus.ex_op == OP_EBREAK);
    w_misaligned   = (bus.ex_result[1:0] != 2'b00);
  end

  assign bus.ex_ready   = (r_state == S_IDLE);
  assign bus.mem_req    = r_memReq;
  assign bus.mem_we     = r_memWe;
  assign bus.mem_addr   = r_memAddr;
  assign bus.mem_wdata  = r_memWdata;
  assign bus.wb_en      = r_wbEn;
  assign bus.wb_rd      = r_wbRd;
  assign bus.wb_data    = r_wbData;
  assign bus.fault      = r_fault;
  assign bus.trap       = r_trap;
  assign bus.trap_cause = r_trapCause;

  // Stage FSM: pulses clear every cycle, accepts in IDLE, waits for ack in MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= 32'd0;
      r_memWdata  <= 32'd0;
      r_memRd     <= 5'd0;
      r_wbEn      <= 1'b0;
      r_wbRd      <= 5'd0;
      r_wbData    <= 32'd0;
      r_fault     <= 1'b0;
      r_trap      <= 1'b0;
      r_trapCause <= 1'b0;
`ifdef MEMWB_TIMEOUT_EN
      r_waitCount <= '0;
`endif
    end else begin
      r_wbEn  <= 1'b0;
      r_fault <= 1'b0;
      r_trap  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.ex_valid) begin
            if (w_writesResult || w_writesLink) begin
              if (bus.ex_rd != 5'd0) begin
                r_wbEn   <= 1'b1;
                r_wbRd   <= bus.ex_rd;
                r_wbData <= w_writesLink ? bus.ex_link : bus.ex_result;
              end
            end else if (w_isTrap) begin
              r_trap      <= 1'b1;
              r_trapCause <= (bus.ex_op == OP_EBREAK);
            end else if (w_isMem) begin
              if (w_misaligned) begin
                r_fault <= 1'b1;
              end else begin
                r_state    <= S_MEM;
                r_memReq   <= 1'b1;
                r_memWe    <= (bus.ex_op == OP_SW);
                r_memAddr  <= bus.ex_result;
                r_memWdata <= bus.ex_store_data;
                r_memRd    <= bus.ex_rd;
`ifdef MEMWB_TIMEOUT_EN
                r_waitCount <= '0;
`endif
              end
            end
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            r_state  <= S_IDLE;
            r_memReq <= 1'b0;
            if (!r_memWe && (r_memRd != 5'd0)) begin
              r_wbEn   <= 1'b1;
              r_wbRd   <= r_memRd;
              r_wbData <= bus.mem_rdata;
            end
          end
`ifdef MEMWB_TIMEOUT_EN
          else if (r_waitCount == LAST_WAIT) begin
            r_state  <= S_IDLE;
            r_memReq <= 1'b0;
            r_fault  <= 1'b1;
          end else begin
            r_waitCount <= r_waitCount + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
